mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 15 +
 rtl/mem_byte_array.sv | 35 +++
 rtl/mem_responder.sv | 99 +++++++++
 tb/tb_mem_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and widths for the mem_responder read/write responder.
// Holds the FSM state encoding and the data path widths.
package mem_responder_pkg;

   localparam int WR_W  = 32;
   localparam int RD_W  = 48;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage

// File: rtl/mem_byte_array.sv
// Byte-addressed storage: 6-byte wrapped combinational read port,
// 4-byte synchronous write port. Contents are not reset.
module mem_byte_array
   import mem_responder_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 1024,
   localparam int AW = $clog2(MEM_BYTES)
) (
   input  logic            clk_i,
   input  logic [AW-1:0]   rd_addr_i,
   output logic [RD_W-1:0] rd_data_o,
   input  logic            wr_en_i,
   input  logic [AW-1:0]   wr_addr_i,
   input  logic [WR_W-1:0] wr_data_i
);

   logic [7:0] mem_q [MEM_BYTES];

   // AW-bit address sums wrap naturally modulo MEM_BYTES
   always_comb begin
      rd_data_o = '0;
      for (int k = 0; k < RD_W / 8; k++) begin
         rd_data_o[8*k +: 8] = mem_q[rd_addr_i + AW'(k)];
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         for (int k = 0; k < WR_W / 8; k++) begin
            mem_q[wr_addr_i + AW'(k)] <= wr_data_i[8*k +: 8];
         end
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding read responder with fixed RD_LAT latency and
// never-stalling writes into a shared byte array.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned RD_LAT    = 2,
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     i_rdaddr,
   input  logic            i_rdvld,
   input  logic [31:0]     i_wraddr,
   input  logic            i_wrvld,
   input  logic [WR_W-1:0] i_wrdata,
   output logic [RD_W-1:0] o_rddata,
   output logic            o_rd_done,
   output logic            o_rd_busy,
   output logic            o_rd_err
);

   localparam int AW = $clog2(MEM_BYTES);
   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(RD_LAT - 1);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [RD_W-1:0]   hold_q;
   logic [RD_W-1:0]   arr_rd;
   logic              done_q;
   logic              busy_q;
   logic              err_q;
   logic              unused_addr;

   assign unused_addr = ^{i_rdaddr[31:AW], i_wraddr[31:AW]};

   mem_byte_array #(
      .MEM_BYTES (MEM_BYTES)
   ) u_arr (
      .clk_i     (clk),
      .rd_addr_i (i_rdaddr[AW-1:0]),
      .rd_data_o (arr_rd),
      .wr_en_i   (i_wrvld),
      .wr_addr_i (i_wraddr[AW-1:0]),
      .wr_data_i (i_wrdata)
   );

   // Snapshot taken from the pre-edge array, so same-edge writes are not seen
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q <= i_rdvld && (state_q != IDLE);
         unique case (state_q)
            IDLE: begin
               if (i_rdvld) begin
                  hold_q <= arr_rd;
                  cnt_q  <= LAT_M1;
                  busy_q <= 1'b1;
                  if (RD_LAT == 1) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               hold_q  <= '0;
            end
            default: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_rddata  = done_q ? hold_q : '0;
   assign o_rd_done = done_q;
   assign o_rd_busy = busy_q;
   assign o_rd_err  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed table-driven bench for mem_responder (RD_LAT=2 and RD_LAT=1).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_mem_responder;

   logic        clk;
   logic        rst;

   logic [31:0] rdaddr, wraddr, wrdata;
   logic        rdvld, wrvld;
   logic [47:0] rddata;
   logic        done, busy, err;

   logic [31:0] r1_rdaddr, r1_wraddr, r1_wrdata;
   logic        r1_rdvld, r1_wrvld;
   logic [47:0] r1_rddata;
   logic        r1_done, r1_busy, r1_err;

   int checks;
   int failures;

   typedef struct {
      logic        rv;
      logic [31:0] ra;
      logic        wv;
      logic [31:0] wa;
      logic [31:0] wd;
      logic        dn;
      logic        bz;
      logic        er;
      logic [47:0] d;
   } vec_t;

   vec_t tv0[$];
   vec_t tv1[$];

   mem_responder #(.RD_LAT(2), .MEM_BYTES(1024)) dut (
      .clk      (clk),
      .rst      (rst),
      .i_rdaddr (rdaddr),
      .i_rdvld  (rdvld),
      .i_wraddr (wraddr),
      .i_wrvld  (wrvld),
      .i_wrdata (wrdata),
      .o_rddata (rddata),
      .o_rd_done(done),
      .o_rd_busy(busy),
      .o_rd_err (err)
   );

   mem_responder #(.RD_LAT(1), .MEM_BYTES(1024)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .i_rdaddr (r1_rdaddr),
      .i_rdvld  (r1_rdvld),
      .i_wraddr (r1_wraddr),
      .i_wrvld  (r1_wrvld),
      .i_wrdata (r1_wrdata),
      .o_rddata (r1_rddata),
      .o_rd_done(r1_done),
      .o_rd_busy(r1_busy),
      .o_rd_err (r1_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t v(logic rv, logic [31:0] ra, logic wv,
                              logic [31:0] wa, logic [31:0] wd,
                              logic dn, logic bz, logic er,
                              logic [47:0] d);
      vec_t r;
      r.rv = rv; r.ra = ra; r.wv = wv; r.wa = wa; r.wd = wd;
      r.dn = dn; r.bz = bz; r.er = er; r.d = d;
      return r;
   endfunction

   task automatic chk(string name, logic [47:0] act, logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic run0(int i, vec_t t);
      rdvld = t.rv; rdaddr = t.ra;
      wrvld = t.wv; wraddr = t.wa; wrdata = t.wd;
      @(negedge clk);
      chk($sformatf("d0_v%0d_done", i), 48'(done), 48'(t.dn));
      chk($sformatf("d0_v%0d_busy", i), 48'(busy), 48'(t.bz));
      chk($sformatf("d0_v%0d_err", i), 48'(err), 48'(t.er));
      chk($sformatf("d0_v%0d_data", i), rddata, t.d);
   endtask

   task automatic run1(int i, vec_t t);
      r1_rdvld = t.rv; r1_rdaddr = t.ra;
      r1_wrvld = t.wv; r1_wraddr = t.wa; r1_wrdata = t.wd;
      @(negedge clk);
      chk($sformatf("d1_v%0d_done", i), 48'(r1_done), 48'(t.dn));
      chk($sformatf("d1_v%0d_busy", i), 48'(r1_busy), 48'(t.bz));
      chk($sformatf("d1_v%0d_err", i), 48'(r1_err), 48'(t.er));
      chk($sformatf("d1_v%0d_data", i), r1_rddata, t.d);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b0;
      rdvld = 0; rdaddr = 0; wrvld = 0; wraddr = 0; wrdata = 0;
      r1_rdvld = 0; r1_rdaddr = 0; r1_wrvld = 0; r1_wraddr = 0; r1_wrdata = 0;

      // RD_LAT=2 vectors
      tv0.push_back(v(0, 0, 1, 'h100, 'h44332211, 0, 0, 0, 0));
      tv0.push_back(v(0, 0, 1, 'h104, 'h00006655, 0, 0, 0, 0));
      tv0.push_back(v(1, 'h100, 0, 0, 0, 0, 1, 0, 0));
      tv0.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 48'h665544332211));
      tv0.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
      tv0.push_back(v(0, 0, 1, 'h3FA, 'h02010000, 0, 0, 0, 0));
      tv0.push_back(v(0, 0, 1, 'h3FE, 'hDEADBEEF, 0, 0, 0, 0));
      tv0.push_back(v(1, 'h3FC, 0, 0, 0, 0, 1, 0, 0));
      tv0.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 48'hDEADBEEF0201));
      tv0.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
      tv0.push_back(v(0, 0, 1, 'h10, 'h0D0C0B0A, 0, 0, 0, 0));
      tv0.push_back(v(0, 0, 1, 'h14, 'h00000F0E, 0, 0, 0, 0));
      tv0.push_back(v(1, 'h10, 0, 0, 0, 0, 1, 0, 0));
      tv0.push_back(v(1, 'h10, 0, 0, 0, 1, 1, 1, 48'h0F0E0D0C0B0A));
      tv0.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
      tv0.push_back(v(0, 0, 1, 'h20, 'h00000000, 0, 0, 0, 0));
      tv0.push_back(v(0, 0, 1, 'h24, 'h00000000, 0, 0, 0, 0));
      tv0.push_back(v(1, 'h20, 1, 'h20, 'hAABBCCDD, 0, 1, 0, 0));
      tv0.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0));
      tv0.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
      tv0.push_back(v(1, 'h20, 0, 0, 0, 0, 1, 0, 0));
      tv0.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 48'h0000AABBCCDD));
      tv0.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
      tv0.push_back(v(1, 'hFFFFF100, 0, 0, 0, 0, 1, 0, 0));
      tv0.push_back(v(0, 0, 1, 'h100, 'hFFFFFFFF, 1, 1, 0, 48'h665544332211));
      tv0.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
      tv0.push_back(v(1, 'h20, 0, 0, 0, 0, 1, 0, 0));
      tv0.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 48'h0000AABBCCDD));
      tv0.push_back(v(1, 'h20, 0, 0, 0, 0, 0, 1, 0));
      tv0.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));

      // RD_LAT=1 vectors
      tv1.push_back(v(0, 0, 1, 'h0, 'h44332211, 0, 0, 0, 0));
      tv1.push_back(v(0, 0, 1, 'h4, 'h88776655, 0, 0, 0, 0));
      tv1.push_back(v(1, 'h0, 0, 0, 0, 1, 1, 0, 48'h665544332211));
      tv1.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
      tv1.push_back(v(1, 'h1, 0, 0, 0, 1, 1, 0, 48'h776655443322));
      tv1.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
      tv1.push_back(v(1, 'h2, 0, 0, 0, 1, 1, 0, 48'h887766554433));
      tv1.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
      tv1.push_back(v(1, 'h0, 0, 0, 0, 1, 1, 0, 48'h665544332211));
      tv1.push_back(v(1, 'h0, 0, 0, 0, 0, 0, 1, 0));
      tv1.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));

      @(negedge clk);
      chk("rst_done", 48'(done), 48'd0);
      chk("rst_busy", 48'(busy), 48'd0);
      chk("rst_err", 48'(err), 48'd0);
      chk("rst_data", rddata, 48'd0);
      rst = 1'b1;

      foreach (tv0[i]) run0(i, tv0[i]);

      // Reset pulse in the middle of a WAIT
      rdvld = 1; rdaddr = 'h100;
      @(negedge clk);
      rdvld = 0;
      chk("ar_busy_pre", 48'(busy), 48'd1);
      #2 rst = 1'b0;
      #1;
      chk("ar_busy", 48'(busy), 48'd0);
      chk("ar_done", 48'(done), 48'd0);
      chk("ar_err", 48'(err), 48'd0);
      chk("ar_data", rddata, 48'd0);
      #1 rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("ar_nodone%0d", k), 48'(done), 48'd0);
         chk($sformatf("ar_idle%0d", k), 48'(busy), 48'd0);
      end
      rdvld = 1; rdaddr = 'h100;
      @(negedge clk);
      rdvld = 0;
      chk("ar_reread_busy", 48'(busy), 48'd1);
      @(negedge clk);
      chk("ar_reread_done", 48'(done), 48'd1);
      chk("ar_reread_data", rddata, 48'h6655FFFFFFFF);

      foreach (tv1[i]) run1(i, tv1[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
